unsigned_restoring_divider_8: RTL
=================================

// Module: unsigned_restoring_divider_8
// PURPOSE
//  Sequential unsigned divider, the inverse of the 8x8 multipliers: recovers the 8-bit factor from a 16-bit product.
//  Computes q = z / y and r = z % y for 2W-bit z and W-bit y, one quotient bit per cycle (restoring, MSB first).
//  Used to check multiplier outputs and in datapaths that need the other factor back.
//  Valid/ready on the input and output sides; one operation in flight.
// PARAMETERS
//  W   8   divisor/quotient/remainder width; dividend is 2*W bits
//  L   2   low quotient bits left uncomputed when APPROX_DIV_TRUNC_EN is defined (0 <= L < W)
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   1    z/y valid
//  in_ready   out  1    block idle, can accept an operation
//  z          in   2W   dividend (product)
//  y          in   W    divisor (known factor)
//  out_valid  out  1    q/r/flags valid
//  out_ready  in   1    consumer accepts result
//  q          out  W    quotient
//  r          out  W    remainder
//  ovf        out  1    quotient does not fit in W bits (z[2W-1:W] >= y, y != 0)
//  dz         out  1    divide by zero (y == 0)
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, q=0, r=0, ovf=0, dz=0; any operation in flight is discarded.
//  in_ready = (state == IDLE). Accept when in_valid && in_ready; z and y are registered on accept.
//  FSM: IDLE -> (accept, special case) -> DONE; IDLE -> (accept, normal) -> RUN; RUN -> (step count hits last) -> DONE;
//    DONE -> (out_ready) -> IDLE. While out_valid=1 and out_ready=0, hold q/r/ovf/dz stable.
//  Special cases, decided at accept, result on the next edge (out_valid one cycle after accept):
//    y == 0              : dz=1, ovf=0, q={W{1}}, r={W{1}}
//    z[2W-1:W] >= y      : dz=0, ovf=1, q={W{1}}, r=0
//  Normal: partial remainder P (W+1 bits) = z[2W-1:W] at accept (< y, so it fits).
//    Step i = W-1..0: T = {P[W-1:0], z[i]}; if T >= y then P = T - y, q[i] = 1; else P = T, q[i] = 0.
//    One step per cycle in RUN; W steps in total; r = P[W-1:0] after the last step.
//  Latency: accept on edge k -> out_valid high after edge k+W+1 (normal). in_ready returns the cycle after the out handshake.
//  No overlap: a new accept is impossible while in RUN or DONE.
//  The out handshake (out_valid && out_ready) clears out_valid on the next edge; flags are valid only with out_valid.
//  rst asserted in any state overrides everything else on that edge.
// CONFIGURATION
//  `APPROX_DIV_TRUNC_EN defined: RUN performs only steps W-1..L (W-L cycles); q[L-1:0] forced 0; r forced 0.
//    Latency becomes W-L+1. The result equals the exact quotient with its low L bits cleared. Special cases unchanged.
//  Not defined: exact division as above; L is ignored.
// STRUCTURE
//  Package div_pkg: state enum {IDLE, RUN, DONE}; default width constant DIV_W=8; step-counter width $clog2(W).
//  Sub-module div_step (combinational): inputs P, dividend bit, y -> outputs next P and the quotient bit.
//    Instantiated once; the top level holds the FSM, step counter, and z/y/P/q registers.
// TESTING
//  z=16'h3A98 (15000), y=8'h7B (123) -> q=8'h79 (121), r=8'h75 (117), ovf=0, dz=0, out_valid 9 cycles after accept.
//  z=16'hFE01, y=8'hFF -> q=8'hFF, r=8'h00; z=16'h00FF, y=8'h01 -> q=8'hFF, r=0, ovf=0.
//  z=16'h1234, y=8'h12 -> ovf=1, q=8'hFF, r=0, out_valid 1 cycle after accept; y=0 -> dz=1, q=r=8'hFF.
//  Back-pressure: out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid ignored until handshake.
//  rst pulsed on step 4 of a divide -> next cycle in_ready=1, out_valid=0, no result produced; the next operation is correct.
//  With APPROX_DIV_TRUNC_EN, L=2: 15000/123 -> q=8'h78 (120), r=0, out_valid 7 cycles after accept.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the restoring divider.
// State encoding plus default width and step-counter width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int DIV_W  = 8;
  localparam int DIV_CW = $clog2(DIV_W);

endpackage

// File: rtl/unsigned_restoring_divider_8_step.sv
// One restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits.
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] p,
  input  logic         zb,
  input  logic [W-1:0] y,
  output logic [W-1:0] p_n,
  output logic         qb
);

  logic [W:0] t;
  logic [W:0] yx;

  assign t  = {p, zb};
  assign yx = {1'b0, y};
  assign qb = (t >= yx);

  // Both results are below y, so the top bit is always zero.
  assign p_n = qb ? W'(t - yx) : W'(t);

endmodule

// File: rtl/unsigned_restoring_divider_8.sv
// Sequential 2W/W unsigned restoring divider, one quotient bit per cycle.
// Define APPROX_DIV_TRUNC_EN to skip the low L quotient bits.
module unsigned_restoring_divider_8
  import div_pkg::*;
#(
  parameter int W = DIV_W,
  parameter int L = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] z,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           ovf,
  output logic           dz
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

`ifdef APPROX_DIV_TRUNC_EN
  localparam logic [CW-1:0] LAST = CW'(L);
`else
  localparam logic [CW-1:0] LAST = '0;
`endif

  if (L < 0 || L >= W) begin : g_bad_l
    $error("L must satisfy 0 <= L < W");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  y_q, y_d;
  logic [W-1:0]  zlo_q, zlo_d;
  logic [W-1:0]  p_q, p_d;
  logic [W-1:0]  quo_q, quo_d;
  logic          sp_ovf_q, sp_ovf_d;
  logic          sp_dz_q, sp_dz_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  r_q, r_d;
  logic          ovf_q, ovf_d;
  logic          dz_q, dz_d;

  logic [W-1:0]  z_hi;
  logic [W-1:0]  step_p;
  logic          step_qb;
  logic [W-1:0]  res_q;
  logic [W-1:0]  res_r;

  assign z_hi      = z[2*W-1:W];
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r         = r_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

  div_step #(.W(W)) u_step (
    .p   (p_q),
    .zb  (zlo_q[W-1]),
    .y   (y_q),
    .p_n (step_p),
    .qb  (step_qb)
  );

  always_comb begin
    res_q = quo_q;
    res_r = p_q;
`ifdef APPROX_DIV_TRUNC_EN
    // Only W-L bits were produced; realign and drop the remainder.
    res_q = quo_q << L;
    res_r = '0;
`endif
    if (sp_dz_q) begin
      res_q = '1;
      res_r = '1;
    end else if (sp_ovf_q) begin
      res_q = '1;
      res_r = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    zlo_d       = zlo_q;
    p_d         = p_q;
    quo_d       = quo_q;
    sp_ovf_d    = sp_ovf_q;
    sp_dz_d     = sp_dz_q;
    out_valid_d = out_valid_q;
    q_d         = q_q;
    r_d         = r_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          y_d      = y;
          zlo_d    = z[W-1:0];
          p_d      = z_hi;
          quo_d    = '0;
          cnt_d    = CW'(W - 1);
          sp_dz_d  = (y == '0);
          sp_ovf_d = (y != '0) && (z_hi >= y);
          if ((y == '0) || (z_hi >= y)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        p_d   = step_p;
        quo_d = {quo_q[W-2:0], step_qb};
        zlo_d = zlo_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          q_d         = res_q;
          r_d         = res_r;
          ovf_d       = sp_ovf_q;
          dz_d        = sp_dz_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      y_q         <= '0;
      zlo_q       <= '0;
      p_q         <= '0;
      quo_q       <= '0;
      sp_ovf_q    <= 1'b0;
      sp_dz_q     <= 1'b0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      zlo_q       <= zlo_d;
      p_q         <= p_d;
      quo_q       <= quo_d;
      sp_ovf_q    <= sp_ovf_d;
      sp_dz_q     <= sp_dz_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
      r_q         <= r_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
    end
  end

endmodule
